// File: rtl/dsp_pkg.sv
// Shared DSP-slice constants: default datapath width and the encodings
// for mask-source selection and auto-reset mode.
package dsp_pkg;

   localparam int unsigned WIDTH       = 48;

   localparam int unsigned MASK_PARAM  = 0;
   localparam int unsigned MASK_C      = 1;
   localparam int unsigned MASK_RND1   = 2;
   localparam int unsigned MASK_RND2   = 3;

   localparam int unsigned AR_NONE     = 0;
   localparam int unsigned AR_MATCH    = 1;
   localparam int unsigned AR_NOTMATCH = 2;

endpackage

// File: rtl/pattern_match_cmp.sv
// Masked pattern comparator: true-pattern and inverse-pattern match of a
// value against a pattern, where mask bits set to 1 are ignored.
module pattern_match_cmp #(
   parameter int unsigned WIDTH = dsp_pkg::WIDTH
) (
   input  logic [WIDTH-1:0] i_p,
   input  logic [WIDTH-1:0] i_pat,
   input  logic [WIDTH-1:0] i_msk,
   output logic             o_m_c,
   output logic             o_mb_c
);

   always_comb begin
      o_m_c  = &((i_p ~^ i_pat) | i_msk);
      o_mb_c = &((i_p ^  i_pat) | i_msk);
   end

endmodule

// File: rtl/pattern_detect_unit.sv
// Pattern-detect stage: registered match flags, their one-cycle-past copies,
// overflow/underflow derivation and the auto-reset request to the P register.
module pattern_detect_unit #(
   parameter int unsigned     WIDTH            = dsp_pkg::WIDTH,
   parameter logic [WIDTH-1:0] PATTERN         = '0,
   parameter logic [WIDTH-1:0] MASK            = WIDTH'(48'h3FFF_FFFF_FFFF),
   parameter int unsigned     SEL_PATTERN      = 0,
   parameter int unsigned     SEL_MASK         = 0,
   parameter int unsigned     PREG             = 1,
   parameter int unsigned     AUTORESET_PATDET = 0
) (
   input  logic             CLK,
   input  logic             RSTP,
   input  logic             CEP,
   input  logic [WIDTH-1:0] P_IN,
   input  logic [WIDTH-1:0] C_IN,
   output logic             PATTERNDETECT,
   output logic             PATTERNBDETECT,
   output logic             PATTERNDETECTPAST,
   output logic             PATTERNBDETECTPAST,
   output logic             OVERFLOW,
   output logic             UNDERFLOW,
   output logic             P_CLR
);

   import dsp_pkg::*;

   localparam bit REG_MODE = (PREG != 0);

   logic [WIDTH-1:0] w_pat;
   logic [WIDTH-1:0] w_msk;
   logic             w_m;
   logic             w_mb;
   logic             w_det_src;
   logic             w_detb_src;
   logic             w_pclr;

   logic             r_det;
   logic             r_detb;
   logic             r_past;
   logic             r_pastb;
   logic             r_clr;

   // Pattern/mask source selection.
   always_comb begin
      w_pat = (SEL_PATTERN != 0) ? C_IN : PATTERN;
      case (SEL_MASK)
         MASK_C:    w_msk = C_IN;
         MASK_RND1: w_msk = (~C_IN) << 1;
         MASK_RND2: w_msk = (~C_IN) << 2;
         default:   w_msk = MASK;
      endcase
   end

   pattern_match_cmp #(
      .WIDTH (WIDTH)
   ) u_cmp (
      .i_p    (P_IN),
      .i_pat  (w_pat),
      .i_msk  (w_msk),
      .o_m_c  (w_m),
      .o_mb_c (w_mb)
   );

   // Past registers follow the visible detect flags in either mode.
   always_comb begin
      w_det_src  = REG_MODE ? r_det  : w_m;
      w_detb_src = REG_MODE ? r_detb : w_mb;
   end

   always_comb begin
      w_pclr = 1'b0;
      if (REG_MODE && !RSTP) begin
         case (AUTORESET_PATDET)
            AR_MATCH:    w_pclr = r_det & CEP;
            AR_NOTMATCH: w_pclr = r_past & ~r_det & CEP;
            default:     w_pclr = 1'b0;
         endcase
      end
   end

   // r_clr marks a 0/0 detect pair caused by an auto-reset, not by the data.
   always_ff @(posedge CLK or posedge RSTP) begin
      if (RSTP) begin
         r_det   <= 1'b0;
         r_detb  <= 1'b0;
         r_past  <= 1'b0;
         r_pastb <= 1'b0;
         r_clr   <= 1'b0;
      end else if (CEP) begin
         r_past  <= w_det_src;
         r_pastb <= w_detb_src;
         if (w_pclr) begin
            r_det  <= 1'b0;
            r_detb <= 1'b0;
            r_clr  <= 1'b1;
         end else begin
            r_det  <= w_m;
            r_detb <= w_mb;
            r_clr  <= 1'b0;
         end
      end
   end

   always_comb begin
      PATTERNDETECT      = ~RSTP & w_det_src;
      PATTERNBDETECT     = ~RSTP & w_detb_src;
      PATTERNDETECTPAST  = r_past;
      PATTERNBDETECTPAST = r_pastb;
      OVERFLOW           = REG_MODE & r_past  & ~r_det & ~r_detb & ~r_clr;
      UNDERFLOW          = REG_MODE & r_pastb & ~r_det & ~r_detb & ~r_clr;
      P_CLR              = w_pclr;
   end

endmodule

// File: tb/tb_pattern_detect_unit.sv
// Scoreboard bench for pattern_detect_unit: five configurations share one
// stimulus stream; expected flag vectors are queued and checked by a monitor.
module tb_pattern_detect_unit;

   localparam int unsigned W    = 48;
   localparam int unsigned NDUT = 5;

   typedef struct {
      logic [NDUT-1:0]   chk;
      logic [7*NDUT-1:0] e;
      string             name;
   } exp_t;

   logic         clk = 1'b0;
   logic         rstp;
   logic         cep;
   logic [W-1:0] p_in;
   logic [W-1:0] c_in;

   logic [6:0] w_o [NDUT];
   exp_t       q [$];
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 clk = ~clk;

   // 0: defaults, registered
   logic pd0, pbd0, pdp0, pbdp0, ov0, un0, clr0;
   pattern_detect_unit u_def (
      .CLK(clk), .RSTP(rstp), .CEP(cep), .P_IN(p_in), .C_IN(c_in),
      .PATTERNDETECT(pd0), .PATTERNBDETECT(pbd0), .PATTERNDETECTPAST(pdp0),
      .PATTERNBDETECTPAST(pbdp0), .OVERFLOW(ov0), .UNDERFLOW(un0), .P_CLR(clr0));

   // 1: C_IN pattern, exact compare, auto-reset on match
   logic pd1, pbd1, pdp1, pbdp1, ov1, un1, clr1;
   pattern_detect_unit #(
      .MASK('0), .SEL_PATTERN(1), .AUTORESET_PATDET(1)
   ) u_ar (
      .CLK(clk), .RSTP(rstp), .CEP(cep), .P_IN(p_in), .C_IN(c_in),
      .PATTERNDETECT(pd1), .PATTERNBDETECT(pbd1), .PATTERNDETECTPAST(pdp1),
      .PATTERNBDETECTPAST(pbdp1), .OVERFLOW(ov1), .UNDERFLOW(un1), .P_CLR(clr1));

   // 2: rounding mask mode 1
   logic pd2, pbd2, pdp2, pbdp2, ov2, un2, clr2;
   pattern_detect_unit #(.SEL_MASK(2)) u_rnd1 (
      .CLK(clk), .RSTP(rstp), .CEP(cep), .P_IN(p_in), .C_IN(c_in),
      .PATTERNDETECT(pd2), .PATTERNBDETECT(pbd2), .PATTERNDETECTPAST(pdp2),
      .PATTERNBDETECTPAST(pbdp2), .OVERFLOW(ov2), .UNDERFLOW(un2), .P_CLR(clr2));

   // 3: rounding mask mode 2
   logic pd3, pbd3, pdp3, pbdp3, ov3, un3, clr3;
   pattern_detect_unit #(.SEL_MASK(3)) u_rnd2 (
      .CLK(clk), .RSTP(rstp), .CEP(cep), .P_IN(p_in), .C_IN(c_in),
      .PATTERNDETECT(pd3), .PATTERNBDETECT(pbd3), .PATTERNDETECTPAST(pdp3),
      .PATTERNBDETECTPAST(pbdp3), .OVERFLOW(ov3), .UNDERFLOW(un3), .P_CLR(clr3));

   // 4: combinational detect with auto-reset requested but inert
   logic pd4, pbd4, pdp4, pbdp4, ov4, un4, clr4;
   pattern_detect_unit #(.PREG(0), .AUTORESET_PATDET(1)) u_preg0 (
      .CLK(clk), .RSTP(rstp), .CEP(cep), .P_IN(p_in), .C_IN(c_in),
      .PATTERNDETECT(pd4), .PATTERNBDETECT(pbd4), .PATTERNDETECTPAST(pdp4),
      .PATTERNBDETECTPAST(pbdp4), .OVERFLOW(ov4), .UNDERFLOW(un4), .P_CLR(clr4));

   // Vector order: {PD, PBD, PDP, PBDP, OV, UN, P_CLR}
   assign w_o[0] = {pd0, pbd0, pdp0, pbdp0, ov0, un0, clr0};
   assign w_o[1] = {pd1, pbd1, pdp1, pbdp1, ov1, un1, clr1};
   assign w_o[2] = {pd2, pbd2, pdp2, pbdp2, ov2, un2, clr2};
   assign w_o[3] = {pd3, pbd3, pdp3, pbdp3, ov3, un3, clr3};
   assign w_o[4] = {pd4, pbd4, pdp4, pbdp4, ov4, un4, clr4};

   // Monitor: one queued expectation per cycle, checked mid-cycle.
   always @(negedge clk) begin
      exp_t x;
      if (q.size() > 0) begin
         x = q.pop_front();
         for (int d = 0; d < NDUT; d++) begin
            if (x.chk[d]) begin
               n_tests++;
               if (w_o[d] !== x.e[d*7 +: 7]) begin
                  n_fail++;
                  $display("FAIL %s dut%0d got %b expected %b", x.name, d, w_o[d], x.e[d*7 +: 7]);
               end
            end
         end
      end
   end

   task automatic step(input logic rst, input logic ce, input logic [W-1:0] p,
                       input logic [W-1:0] c, input logic [NDUT-1:0] chk,
                       input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2,
                       input logic [6:0] e3, input logic [6:0] e4, input string name);
      exp_t x;
      @(posedge clk);
      #1;
      rstp = rst;
      cep  = ce;
      p_in = p;
      c_in = c;
      x.chk  = chk;
      x.e    = {e4, e3, e2, e1, e0};
      x.name = name;
      q.push_back(x);
   endtask

   localparam logic [W-1:0] P_MATCH = 48'h0000_1234_0000;
   localparam logic [W-1:0] P_01    = 48'h4000_0000_0000;
   localparam logic [W-1:0] P_10    = 48'h8000_0000_0000;
   localparam logic [W-1:0] P_11    = 48'hC000_0000_0000;
   localparam logic [W-1:0] P_NEG   = 48'hFFFF_FFFF_FFF0;

   initial begin
      rstp = 1'b1;
      cep  = 1'b1;
      p_in = '0;
      c_in = '0;

      step(1, 1, '0, '0, 5'b11111, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0, "reset");
      step(0, 1, P_MATCH, '0, 5'b10001, 7'b0000000, 7'b0, 7'b0, 7'b0, 7'b1000000, "match_pre");
      step(0, 1, P_MATCH, '0, 5'b10001, 7'b1000000, 7'b0, 7'b0, 7'b0, 7'b1010000, "match_lat1");
      step(0, 1, P_MATCH, '0, 5'b10001, 7'b1010000, 7'b0, 7'b0, 7'b0, 7'b1010000, "match_past");
      step(1, 1, P_MATCH, '0, 5'b11111, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0, "reset_midrun");

      step(0, 1, 48'h5, '0, 5'b00001, 7'b0000000, 7'b0, 7'b0, 7'b0, 7'b0, "ovf_rel");
      step(0, 1, P_01,  '0, 5'b00001, 7'b1000000, 7'b0, 7'b0, 7'b0, 7'b0, "ovf_det");
      step(0, 1, P_01,  '0, 5'b00001, 7'b0010100, 7'b0, 7'b0, 7'b0, 7'b0, "overflow");
      step(0, 1, P_NEG, '0, 5'b00001, 7'b0000000, 7'b0, 7'b0, 7'b0, 7'b0, "ovf_end");
      step(0, 1, P_10,  '0, 5'b00001, 7'b0100000, 7'b0, 7'b0, 7'b0, 7'b0, "udf_detb");
      step(0, 1, P_10,  '0, 5'b00001, 7'b0001010, 7'b0, 7'b0, 7'b0, 7'b0, "underflow");
      step(0, 1, P_10,  '0, 5'b00001, 7'b0000000, 7'b0, 7'b0, 7'b0, 7'b0, "udf_end");

      step(0, 1, '0,   '0, 5'b00001, 7'b0000000, 7'b0, 7'b0, 7'b0, 7'b0, "cep_pre");
      step(0, 1, '0,   '0, 5'b00001, 7'b1000000, 7'b0, 7'b0, 7'b0, 7'b0, "cep_det");
      step(0, 1, '0,   '0, 5'b00001, 7'b1010000, 7'b0, 7'b0, 7'b0, 7'b0, "cep_past");
      step(0, 0, P_01, '0, 5'b00001, 7'b1010000, 7'b0, 7'b0, 7'b0, 7'b0, "cep_off");
      step(0, 0, P_01, '0, 5'b00001, 7'b1010000, 7'b0, 7'b0, 7'b0, 7'b0, "cep_hold1");
      step(0, 0, P_01, '0, 5'b00001, 7'b1010000, 7'b0, 7'b0, 7'b0, 7'b0, "cep_hold2");
      step(0, 1, P_01, '0, 5'b00001, 7'b1010000, 7'b0, 7'b0, 7'b0, 7'b0, "cep_hold3");
      step(0, 1, P_01, '0, 5'b00001, 7'b0010100, 7'b0, 7'b0, 7'b0, 7'b0, "cep_resume");

      step(1, 1, 48'h64, 48'h64, 5'b11111, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0, "ar_reset");
      step(0, 1, 48'h64, 48'h64, 5'b00010, 7'b0, 7'b0000000, 7'b0, 7'b0, 7'b0, "ar_pre");
      step(0, 1, 48'h64, 48'h64, 5'b00010, 7'b0, 7'b1000001, 7'b0, 7'b0, 7'b0, "ar_pclr");
      step(0, 1, 48'h64, 48'h64, 5'b00010, 7'b0, 7'b0010000, 7'b0, 7'b0, 7'b0, "ar_cleared");
      step(0, 1, 48'h64, 48'h64, 5'b00010, 7'b0, 7'b1000001, 7'b0, 7'b0, 7'b0, "ar_rematch");
      step(0, 1, 48'h65, 48'h64, 5'b00010, 7'b0, 7'b0010000, 7'b0, 7'b0, 7'b0, "ar_clear2");
      step(0, 1, 48'h65, 48'h64, 5'b00010, 7'b0, 7'b0000000, 7'b0, 7'b0, 7'b0, "ar_nomatch");

      step(1, 1, 48'h8,  48'h3, 5'b11111, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0, "rnd_reset");
      step(0, 1, 48'h8,  48'h3, 5'b01100, 7'b0, 7'b0, 7'b0000000, 7'b0000000, 7'b0, "rnd_pre");
      step(0, 1, 48'h7,  48'h3, 5'b01100, 7'b0, 7'b0, 7'b1000000, 7'b0000000, 7'b0, "rnd_p8");
      step(0, 1, 48'h10, 48'h3, 5'b01100, 7'b0, 7'b0, 7'b0110000, 7'b0000000, 7'b0, "rnd_p7");
      step(0, 1, 48'h10, 48'h3, 5'b01100, 7'b0, 7'b0, 7'b1001000, 7'b1000000, 7'b0, "rnd_p10");

      step(0, 1, '0,   48'h3, 5'b10000, 7'b0, 7'b0, 7'b0, 7'b0, 7'b1010000, "p0_m1");
      step(0, 1, P_01, 48'h3, 5'b10000, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0010000, "p0_n1");
      step(0, 1, '0,   48'h3, 5'b10000, 7'b0, 7'b0, 7'b0, 7'b0, 7'b1000000, "p0_m2");
      step(0, 1, P_11, 48'h3, 5'b10000, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0110000, "p0_b");
      step(0, 1, P_01, 48'h3, 5'b10000, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0001000, "p0_n2");
      step(0, 1, '0,   48'h3, 5'b10000, 7'b0, 7'b0, 7'b0, 7'b0, 7'b1000000, "p0_m3");

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain queue left %0d entries, required 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pattern_detect_unit.md
Name: pattern_detect_unit

Overview:
- Pattern-detect stage of the DSP slice. Takes the pre-register ALU result P_IN and compares it against a pattern under a mask, producing match and inverse-match flags.
- Keeps one-cycle-past copies of both flags and derives OVERFLOW/UNDERFLOW from them.
- Generates the auto-reset request P_CLR back to the P output register.
- Sits between the ALU output and the P/pattern output register stage; P_IN is sampled on the same edge as the P register.

Parameters:
- WIDTH, 48: datapath width of P_IN, C_IN, PATTERN, MASK.
- PATTERN, 48'h0: static pattern, used when SEL_PATTERN=0.
- MASK, 48'h3FFF_FFFF_FFFF: static mask; bit=1 means ignore that bit. Used when SEL_MASK=0.
- SEL_PATTERN, 0: 0 = PATTERN parameter, 1 = C_IN.
- SEL_MASK, 0: 0 = MASK parameter, 1 = C_IN, 2 = rounding mode 1 (~C_IN<<1), 3 = rounding mode 2 (~C_IN<<2).
- PREG, 1: 1 = registered detect outputs; 0 = combinational detect outputs.
- AUTORESET_PATDET, 0: 0 = no reset, 1 = reset on match, 2 = reset on not-match after match.

Ports:
- CLK  in  1  slice clock.
- RSTP  in  1  asynchronous, active-high reset of all detect state.
- CEP  in  1  clock enable for all detect/past registers (enable mux, no clock gating).
- P_IN  in  WIDTH  ALU result feeding the P register.
- C_IN  in  WIDTH  C operand, registered upstream, used as dynamic pattern/mask.
- PATTERNDETECT  out  1  match flag.
- PATTERNBDETECT  out  1  inverse-pattern match flag.
- PATTERNDETECTPAST  out  1  PATTERNDETECT delayed one enabled cycle.
- PATTERNBDETECTPAST  out  1  PATTERNBDETECT delayed one enabled cycle.
- OVERFLOW  out  1  overflow indication.
- UNDERFLOW  out  1  underflow indication.
- P_CLR  out  1  auto-reset request to the P register, combinational.

Behaviour:
- Reset: RSTP=1 asynchronously clears the detect, detectb, past and pastb registers to 0. While RSTP=1, every output is 0, P_CLR included.
- Effective pattern: pat = SEL_PATTERN ? C_IN : PATTERN.
- Effective mask, msk: MASK, C_IN, ~C_IN<<1 or ~C_IN<<2 per SEL_MASK; shifts fill with 0 and truncate to WIDTH.
- Compare:
  - m = &((P_IN ~^ pat) | msk)
  - mb = &((P_IN ^ pat) | msk)
  - Both can be 1 simultaneously only if msk is all ones.
- PREG=1:
  - On a rising CLK edge with CEP=1: det<=m, detb<=mb, past<=det, pastb<=detb.
  - Latency from P_IN to PATTERNDETECT is 1 cycle; PATTERNDETECTPAST follows 1 cycle later.
  - CEP=0 holds all four registers.
- PREG=0:
  - PATTERNDETECT=m and PATTERNBDETECT=mb, combinational.
  - Past registers still load m/mb on CEP.
  - OVERFLOW, UNDERFLOW and P_CLR are forced to 0.
- OVERFLOW = past & ~det & ~detb.
- UNDERFLOW = pastb & ~det & ~detb.
- P_CLR:
  - Mode 1: det & CEP.
  - Mode 2: past & ~det & CEP.
  - Mode 0: always 0.
- Edge where P_CLR=1 and CEP=1:
  - det and detb load 0, not m/mb, because P is cleared on that edge.
  - past/pastb load the current det/detb as normal.
- Priority: RSTP > auto-reset clear > CEP load > hold.
- Reset released mid-operation: the first enabled edge loads from P_IN normally. Past flags stay 0 until the second enabled edge, so no spurious OVERFLOW/UNDERFLOW.

Decomposition:
- Shared package dsp_pkg holds:
  - WIDTH default 48.
  - SEL_MASK encodings: MASK_PARAM=0, MASK_C=1, MASK_RND1=2, MASK_RND2=3.
  - AUTORESET encodings: AR_NONE=0, AR_MATCH=1, AR_NOTMATCH=2.
- Natural sub-module: pattern_match_cmp. It is combinational (P_IN, pat, msk -> m, mb) and is reused by any future cascade detect.
- The register, past and auto-reset logic stays in pattern_detect_unit.

Test Plan:
- Reset/basic match: PREG=1, defaults, drive RSTP=1 mid-run -> all outputs 0 immediately. Then P_IN=48'h0000_1234_0000 with mask 48'h3FFF_FFFF_FFFF -> PATTERNDETECT=1 one cycle later, PATTERNDETECTPAST=1 two cycles later.
- Overflow: pattern 0, mask upper 2 bits compared. P_IN=48'h0000_0000_0005 then 48'h4000_0000_0000 -> cycle N+2: det=0, detb=0, past=1, OVERFLOW=1, UNDERFLOW=0.
- Underflow: P_IN=48'hFFFF_FFFF_FFF0 then 48'h8000_0000_0000 -> UNDERFLOW=1 for one cycle, OVERFLOW=0.
- CEP hold: match registered, CEP=0 for 3 cycles while P_IN changes to a non-match -> all flags unchanged. CEP=1 -> update on the next edge.
- Autoreset mode 1: P_IN matches 48'h0000_0000_0064 via C_IN pattern -> P_CLR=1 that cycle. The next edge gives det=0 and past=1, with no OVERFLOW while det and detb are both 0 only because the clear is flagged; the bench also checks the rounding-mask variants SEL_MASK=2/3 with C_IN=48'h0000_0000_0003 giving the expected msk.
- PREG=0: P_IN toggles match/non-match each cycle -> PATTERNDETECT follows combinationally; OVERFLOW, UNDERFLOW and P_CLR stay 0 throughout.
